// File: rtl/battleship_shot_ctrl_if.sv
// Shot handshake, hit-lookup and result/status bundle for battleship_shot_ctrl.
// The slave modport is the controller side; the master modport is the front end / lookup side.
interface battleship_shot_ctrl_if;
   logic       start;
   logic       shot_valid;
   logic       shot_ready;
   logic [3:0] shot_x;
   logic [3:0] shot_y;
   logic [3:0] lookup_x;
   logic [3:0] lookup_y;
   logic       lookup_hit;
   logic       res_valid;
   logic       res_hit;
   logic       res_invalid;
   logic       res_repeat;
   logic [4:0] hit_count;
   logic [5:0] shots_left;
   logic       game_won;
   logic       game_lost;

   modport slave (
      input  start, shot_valid, shot_x, shot_y, lookup_hit,
      output shot_ready, lookup_x, lookup_y, res_valid, res_hit, res_invalid,
             res_repeat, hit_count, shots_left, game_won, game_lost
   );

   modport master (
      output start, shot_valid, shot_x, shot_y, lookup_hit,
      input  shot_ready, lookup_x, lookup_y, res_valid, res_hit, res_invalid,
             res_repeat, hit_count, shots_left, game_won, game_lost
   );
endinterface

// File: rtl/battleship_shot_ctrl.sv
// Single-player shot sequencer: accepts, range-checks and de-duplicates shots, queries the hit lookup, tracks score.
// Optional shot limit and loss state enabled by defining BATTLESHIP_SHOT_LIMIT_EN.
module battleship_shot_ctrl #(
   parameter int BOARD_DIM  = 10,
   parameter int TOTAL_HITS = 19,
   parameter int MAX_SHOTS  = 40
) (
   input logic                  clock,
   input logic                  reset_L,
   battleship_shot_ctrl_if.slave bus
);

   localparam int         CELLS  = BOARD_DIM * BOARD_DIM;
   localparam int         IDX_W  = $clog2(CELLS);
   localparam logic [3:0] DIM_C  = 4'(BOARD_DIM);
   localparam logic [4:0] HITS_C = 5'(TOTAL_HITS);

   if (MAX_SHOTS < 0 || MAX_SHOTS > 63) begin : g_bad_max_shots
      $error("MAX_SHOTS must fit in the 6-bit shots_left counter");
   end

   typedef enum logic [2:0] {IDLE, WAIT, CHECK, REPORT, WON, LOST} state_t;

   state_t           state_q, state_d;
   logic [3:0]       x_q, x_d, y_q, y_d;
   logic [CELLS-1:0] bitmap_q, bitmap_d;
   logic [4:0]       hit_count_q, hit_count_d;
   logic             res_hit_q, res_hit_d;
   logic             res_invalid_q, res_invalid_d;
   logic             res_repeat_q, res_repeat_d;
   logic [5:0]       shots_left_q;
   logic             in_range, is_repeat, legal_shot, game_start, out_of_shots;
   logic [IDX_W-1:0] cell_idx;

   always_comb begin
      in_range   = (x_q != 4'd0) && (x_q <= DIM_C) && (y_q != 4'd0) && (y_q <= DIM_C);
      cell_idx   = IDX_W'((int'(x_q) - 1) * BOARD_DIM + (int'(y_q) - 1));
      // cell_idx is only meaningful for in-range coordinates, so every use is gated by in_range
      is_repeat  = in_range && bitmap_q[cell_idx];
      legal_shot = (state_q == CHECK) && in_range && !is_repeat;
      game_start = bus.start && (state_q == IDLE || state_q == WON || state_q == LOST);
   end

`ifdef BATTLESHIP_SHOT_LIMIT_EN
   localparam logic [5:0] SHOTS_C = 6'(MAX_SHOTS);
   logic [5:0] shots_left_d;

   always_comb begin
      shots_left_d = shots_left_q;
      if (game_start)
         shots_left_d = SHOTS_C;
      else if (legal_shot && shots_left_q != 6'd0)
         shots_left_d = shots_left_q - 6'd1;
   end

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) shots_left_q <= '0;
      else          shots_left_q <= shots_left_d;
   end

   assign out_of_shots = (shots_left_q == 6'd0);
`else
   assign shots_left_q = '0;
   assign out_of_shots = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = WAIT;
         WAIT:    if (bus.shot_valid) state_d = CHECK;
         CHECK:   state_d = REPORT;
         REPORT: begin
            if (hit_count_q == HITS_C) state_d = WON;
            else if (out_of_shots)     state_d = LOST;
            else                       state_d = WAIT;
         end
         WON, LOST: if (bus.start) state_d = WAIT;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.shot_ready  = (state_q == WAIT);
      bus.res_valid   = (state_q == REPORT);
      bus.lookup_x    = (state_q == CHECK) ? x_q : 4'd0;
      bus.lookup_y    = (state_q == CHECK) ? y_q : 4'd0;
      bus.res_hit     = res_hit_q;
      bus.res_invalid = res_invalid_q;
      bus.res_repeat  = res_repeat_q;
      bus.hit_count   = hit_count_q;
      bus.shots_left  = shots_left_q;
      bus.game_won    = (state_q == WON);
`ifdef BATTLESHIP_SHOT_LIMIT_EN
      bus.game_lost   = (state_q == LOST);
`else
      bus.game_lost   = 1'b0;
`endif
   end

   // Result flags are captured at the end of CHECK and held until the next classification
   always_comb begin
      x_d           = x_q;
      y_d           = y_q;
      bitmap_d      = bitmap_q;
      hit_count_d   = hit_count_q;
      res_hit_d     = res_hit_q;
      res_invalid_d = res_invalid_q;
      res_repeat_d  = res_repeat_q;
      if (game_start) begin
         bitmap_d    = '0;
         hit_count_d = '0;
      end
      if (state_q == WAIT && bus.shot_valid) begin
         x_d = bus.shot_x;
         y_d = bus.shot_y;
      end
      if (state_q == CHECK) begin
         res_invalid_d = !in_range;
         res_repeat_d  = is_repeat;
         res_hit_d     = legal_shot && bus.lookup_hit;
         if (legal_shot) begin
            bitmap_d[cell_idx] = 1'b1;
            if (bus.lookup_hit && hit_count_q < HITS_C)
               hit_count_d = hit_count_q + 5'd1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         x_q           <= '0;
         y_q           <= '0;
         bitmap_q      <= '0;
         hit_count_q   <= '0;
         res_hit_q     <= 1'b0;
         res_invalid_q <= 1'b0;
         res_repeat_q  <= 1'b0;
      end else begin
         x_q           <= x_d;
         y_q           <= y_d;
         bitmap_q      <= bitmap_d;
         hit_count_q   <= hit_count_d;
         res_hit_q     <= res_hit_d;
         res_invalid_q <= res_invalid_d;
         res_repeat_q  <= res_repeat_d;
      end
   end

endmodule

// File: tb/tb_battleship_shot_ctrl.sv
// Scoreboard bench for battleship_shot_ctrl: dut_a (MAX_SHOTS=40) plays a full game, dut_b (MAX_SHOTS=3) exercises the shot limit.
module tb_battleship_shot_ctrl;

   typedef struct packed {
      logic       hit;
      logic       inv;
      logic       rep;
      logic [4:0] hc;
      logic [5:0] sl;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset_L;
   logic       sel, tb_start, tb_valid;
   logic [3:0] tb_x, tb_y;
   int         total = 0;
   int         bad   = 0;
   exp_t       qa[$];
   exp_t       qb[$];
   exp_t       ea, eb;

   // Ship cells other than (2,9), packed as {x,y}
   logic [7:0] ships [18] = '{8'h25, 8'h26, 8'h27, 8'h28, 8'h42, 8'h52, 8'h62, 8'h72, 8'h94,
                              8'h95, 8'h96, 8'h57, 8'h67, 8'h77, 8'hA9, 8'hAA, 8'h7A, 8'h8A};

   always #5 clock = ~clock;

   battleship_shot_ctrl_if ifa ();
   battleship_shot_ctrl_if ifb ();

   battleship_shot_ctrl #(.BOARD_DIM(10), .TOTAL_HITS(19), .MAX_SHOTS(40)) dut_a (
      .clock(clock), .reset_L(reset_L), .bus(ifa.slave));
   battleship_shot_ctrl #(.BOARD_DIM(10), .TOTAL_HITS(19), .MAX_SHOTS(3)) dut_b (
      .clock(clock), .reset_L(reset_L), .bus(ifb.slave));

   function automatic logic is_ship(input logic [3:0] x, input logic [3:0] y);
      logic r;
      r = ({x, y} == 8'h29);
      for (int i = 0; i < 18; i++) if (ships[i] == {x, y}) r = 1'b1;
      return r;
   endfunction

   function automatic int sl(input int n);
`ifdef BATTLESHIP_SHOT_LIMIT_EN
      return n;
`else
      return 0 * n;
`endif
   endfunction

   assign ifa.start      = tb_start & ~sel;
   assign ifb.start      = tb_start & sel;
   assign ifa.shot_valid = tb_valid & ~sel;
   assign ifb.shot_valid = tb_valid & sel;
   assign ifa.shot_x     = tb_x;
   assign ifa.shot_y     = tb_y;
   assign ifb.shot_x     = tb_x;
   assign ifb.shot_y     = tb_y;
   assign ifa.lookup_hit = is_ship(ifa.lookup_x, ifa.lookup_y);
   assign ifb.lookup_hit = is_ship(ifb.lookup_x, ifb.lookup_y);

   logic       cur_ready;
   logic [3:0] cur_lx, cur_ly;
   assign cur_ready = sel ? ifb.shot_ready : ifa.shot_ready;
   assign cur_lx    = sel ? ifb.lookup_x : ifa.lookup_x;
   assign cur_ly    = sel ? ifb.lookup_y : ifa.lookup_y;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (ifa.res_valid) begin
         if (qa.size() == 0) chk("a_unexpected_res_valid", 1, 0);
         else begin
            ea = qa.pop_front();
            chk("a_res_hit", int'(ifa.res_hit), int'(ea.hit));
            chk("a_res_invalid", int'(ifa.res_invalid), int'(ea.inv));
            chk("a_res_repeat", int'(ifa.res_repeat), int'(ea.rep));
            chk("a_hit_count", int'(ifa.hit_count), int'(ea.hc));
            chk("a_shots_left", int'(ifa.shots_left), int'(ea.sl));
         end
      end
   end

   always @(negedge clock) begin
      if (ifb.res_valid) begin
         if (qb.size() == 0) chk("b_unexpected_res_valid", 1, 0);
         else begin
            eb = qb.pop_front();
            chk("b_res_hit", int'(ifb.res_hit), int'(eb.hit));
            chk("b_res_invalid", int'(ifb.res_invalid), int'(eb.inv));
            chk("b_res_repeat", int'(ifb.res_repeat), int'(eb.rep));
            chk("b_hit_count", int'(ifb.hit_count), int'(eb.hc));
            chk("b_shots_left", int'(ifb.shots_left), int'(eb.sl));
         end
      end
   end

   task automatic fire(input logic [3:0] x, input logic [3:0] y, input logic h,
                       input logic inv, input logic rep, input int hc, input int s);
      int   n = 0;
      exp_t e;
      e = '{hit: h, inv: inv, rep: rep, hc: 5'(hc), sl: 6'(s)};
      while (!cur_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (!cur_ready) begin
         chk("shot_ready_timeout", 0, 1);
         return;
      end
      if (sel) qb.push_back(e);
      else     qa.push_back(e);
      tb_valid = 1'b1;
      tb_x     = x;
      tb_y     = y;
      @(posedge clock);
      @(negedge clock);
      tb_valid = 1'b0;
      chk("lookup_x", int'(cur_lx), int'(x));
      chk("lookup_y", int'(cur_ly), int'(y));
      @(negedge clock);
      @(negedge clock);
   endtask

   task automatic pulse_start();
      tb_start = 1'b1;
      @(negedge clock);
      tb_start = 1'b0;
   endtask

   task automatic check_a_zero(input string tag);
      chk({tag, "_shot_ready"}, int'(ifa.shot_ready), 0);
      chk({tag, "_res_valid"}, int'(ifa.res_valid), 0);
      chk({tag, "_res_hit"}, int'(ifa.res_hit), 0);
      chk({tag, "_res_invalid"}, int'(ifa.res_invalid), 0);
      chk({tag, "_res_repeat"}, int'(ifa.res_repeat), 0);
      chk({tag, "_hit_count"}, int'(ifa.hit_count), 0);
      chk({tag, "_shots_left"}, int'(ifa.shots_left), 0);
      chk({tag, "_game_won"}, int'(ifa.game_won), 0);
      chk({tag, "_game_lost"}, int'(ifa.game_lost), 0);
      chk({tag, "_lookup_x"}, int'(ifa.lookup_x), 0);
      chk({tag, "_lookup_y"}, int'(ifa.lookup_y), 0);
   endtask

   initial begin
      int n;
      sel      = 1'b1;
      tb_start = 1'b0;
      tb_valid = 1'b0;
      tb_x     = 4'd0;
      tb_y     = 4'd0;
      reset_L  = 1'b0;
      repeat (3) @(negedge clock);
      check_a_zero("rst");
      reset_L = 1'b1;
      @(negedge clock);

      // Shot limit on dut_b: three legal misses
      pulse_start();
      chk("b_ready_after_start", int'(ifb.shot_ready), 1);
      chk("b_shots_after_start", int'(ifb.shots_left), sl(3));
      fire(4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 0, sl(2));
      fire(4'd1, 4'd3, 1'b0, 1'b0, 1'b0, 0, sl(1));
      fire(4'd1, 4'd4, 1'b0, 1'b0, 1'b0, 0, sl(0));
`ifdef BATTLESHIP_SHOT_LIMIT_EN
      chk("b_game_lost", int'(ifb.game_lost), 1);
      chk("b_ready_when_lost", int'(ifb.shot_ready), 0);
`else
      chk("b_game_lost", int'(ifb.game_lost), 0);
      chk("b_ready_unlimited", int'(ifb.shot_ready), 1);
`endif
      chk("b_game_won", int'(ifb.game_won), 0);

      // Full game on dut_a
      sel = 1'b0;
      @(negedge clock);
      pulse_start();
      chk("a_ready_after_start", int'(ifa.shot_ready), 1);
      chk("a_shots_after_start", int'(ifa.shots_left), sl(40));
      fire(4'd2, 4'd9, 1'b1, 1'b0, 1'b0, 1, sl(39));
      fire(4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1, sl(38));
      fire(4'd0, 4'd5, 1'b0, 1'b1, 1'b0, 1, sl(38));
      fire(4'd11, 4'd3, 1'b0, 1'b1, 1'b0, 1, sl(38));
      fire(4'd2, 4'd9, 1'b0, 1'b0, 1'b1, 1, sl(38));
      fire(4'd5, 4'd0, 1'b0, 1'b1, 1'b0, 1, sl(38));
      for (int i = 0; i < 18; i++) begin
         logic [7:0] c;
         c = ships[i];
         fire(c[7:4], c[3:0], 1'b1, 1'b0, 1'b0, i + 2, sl(37 - i));
      end
      chk("a_game_won", int'(ifa.game_won), 1);
      chk("a_hit_count_won", int'(ifa.hit_count), 19);
      chk("a_ready_when_won", int'(ifa.shot_ready), 0);
      chk("a_game_lost_when_won", int'(ifa.game_lost), 0);
      repeat (2) @(negedge clock);
      chk("a_game_won_holds", int'(ifa.game_won), 1);

      pulse_start();
      chk("a_won_cleared", int'(ifa.game_won), 0);
      chk("a_hit_count_restart", int'(ifa.hit_count), 0);
      chk("a_ready_restart", int'(ifa.shot_ready), 1);
      chk("a_shots_restart", int'(ifa.shots_left), sl(40));
      fire(4'd2, 4'd9, 1'b1, 1'b0, 1'b0, 1, sl(39));

      // Reset asserted while the shot sits in CHECK: no result may follow
      n = 0;
      while (!ifa.shot_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      chk("a_ready_before_midreset", int'(ifa.shot_ready), 1);
      tb_valid = 1'b1;
      tb_x     = 4'd3;
      tb_y     = 4'd3;
      @(posedge clock);
      @(negedge clock);
      tb_valid = 1'b0;
      chk("a_midreset_lookup_x", int'(ifa.lookup_x), 3);
      reset_L = 1'b0;
      #1;
      check_a_zero("midrst");
      @(negedge clock);
      reset_L = 1'b1;
      repeat (4) @(negedge clock);
      chk("a_idle_after_reset", int'(ifa.shot_ready), 0);

      chk("a_queue_drained", qa.size(), 0);
      chk("b_queue_drained", qb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
